song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_pkg.sv | 61 ++++++
 rtl/song_rom.sv | 42 ++++
 rtl/song_sequencer.sv | 156 +++++++++++++++
 tb/tb_song_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared types, constants and the note-to-terminal-count lookup for the song sequencer.
package song_pkg;

  localparam int unsigned DUR_W  = 12;
  localparam int unsigned HP_W   = 17;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CODE_W = 4;

  // Note codes; REST plays silence.
  typedef enum logic [CODE_W-1:0] {
    REST = 4'd0,
    G4   = 4'd1,
    A4   = 4'd2,
    B4   = 4'd3,
    C5   = 4'd4,
    D5   = 4'd5,
    E5   = 4'd6,
    F5   = 4'd7,
    G5   = 4'd8
  } note_e;

  // Tone-divider terminal counts at 100 MHz.
  localparam logic [HP_W-1:0] HP_G4 = 17'd127_551;
  localparam logic [HP_W-1:0] HP_A4 = 17'd113_636;
  localparam logic [HP_W-1:0] HP_B4 = 17'd101_239;
  localparam logic [HP_W-1:0] HP_C5 = 17'd95_556;
  localparam logic [HP_W-1:0] HP_D5 = 17'd85_131;
  localparam logic [HP_W-1:0] HP_E5 = 17'd75_844;
  localparam logic [HP_W-1:0] HP_F5 = 17'd71_586;
  localparam logic [HP_W-1:0] HP_G5 = 17'd63_776;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  // One ROM word: note code plus its duration in ms.
  typedef struct packed {
    note_e            code;
    logic [DUR_W-1:0] dur_ms;
  } rom_entry_t;

  // Map a note code to the tone-divider terminal count; REST and unknown codes give 0.
  function automatic logic [HP_W-1:0] half_period_of(input note_e code);
    case (code)
      G4:      return HP_G4;
      A4:      return HP_A4;
      B4:      return HP_B4;
      C5:      return HP_C5;
      D5:      return HP_D5;
      E5:      return HP_E5;
      F5:      return HP_F5;
      G5:      return HP_G5;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song table: Happy Birthday in C, four phrases.
module song_rom
  import song_pkg::*;
(
  input  logic [IDX_W-1:0] addr_i,
  output rom_entry_t       entry_c_o
);

  // Table lookup; out-of-range addresses read as a zero-length rest.
  always_comb begin
    entry_c_o = '{code: REST, dur_ms: 12'd0};
    case (addr_i)
      5'd0:  entry_c_o = '{code: G4, dur_ms: 12'd250};
      5'd1:  entry_c_o = '{code: G4, dur_ms: 12'd250};
      5'd2:  entry_c_o = '{code: A4, dur_ms: 12'd500};
      5'd3:  entry_c_o = '{code: G4, dur_ms: 12'd500};
      5'd4:  entry_c_o = '{code: C5, dur_ms: 12'd500};
      5'd5:  entry_c_o = '{code: B4, dur_ms: 12'd1000};
      5'd6:  entry_c_o = '{code: G4, dur_ms: 12'd250};
      5'd7:  entry_c_o = '{code: G4, dur_ms: 12'd250};
      5'd8:  entry_c_o = '{code: A4, dur_ms: 12'd500};
      5'd9:  entry_c_o = '{code: G4, dur_ms: 12'd500};
      5'd10: entry_c_o = '{code: D5, dur_ms: 12'd500};
      5'd11: entry_c_o = '{code: C5, dur_ms: 12'd1000};
      5'd12: entry_c_o = '{code: G4, dur_ms: 12'd250};
      5'd13: entry_c_o = '{code: G4, dur_ms: 12'd250};
      5'd14: entry_c_o = '{code: G5, dur_ms: 12'd500};
      5'd15: entry_c_o = '{code: E5, dur_ms: 12'd500};
      5'd16: entry_c_o = '{code: C5, dur_ms: 12'd500};
      5'd17: entry_c_o = '{code: B4, dur_ms: 12'd500};
      5'd18: entry_c_o = '{code: A4, dur_ms: 12'd1000};
      5'd19: entry_c_o = '{code: F5, dur_ms: 12'd250};
      5'd20: entry_c_o = '{code: F5, dur_ms: 12'd250};
      5'd21: entry_c_o = '{code: E5, dur_ms: 12'd500};
      5'd22: entry_c_o = '{code: C5, dur_ms: 12'd500};
      5'd23: entry_c_o = '{code: D5, dur_ms: 12'd500};
      5'd24: entry_c_o = '{code: C5, dur_ms: 12'd1000};
      default: ;
    endcase
  end

endmodule

// File: rtl/song_sequencer.sv
// Plays the song ROM note by note: LOAD latches a note, PLAY holds it for its duration,
// GAP inserts a fixed silence, DONE pulses once at the end of the song.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned MS_DIV   = 100_000,
  parameter int unsigned GAP_MS   = 50,
  parameter int unsigned SONG_LEN = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  output logic            busy,
  output logic            done,
  output logic            note_en,
  output logic [HP_W-1:0] half_period,
  output logic [IDX_W-1:0] note_idx
);

  localparam int unsigned PRE_W   = $clog2(MS_DIV + 1);
  localparam int unsigned GAP_EFF = (GAP_MS == 0) ? 1 : GAP_MS;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_EFF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

  state_e            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUR_W-1:0]  ms_q, ms_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  note_e             code_q, code_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [HP_W-1:0]   half_q, half_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              note_en_q, note_en_d;

  rom_entry_t        rom_entry;
  logic              ms_tick;
  logic [DUR_W-1:0]  play_last;

  song_rom u_rom (
    .addr_i    (idx_q),
    .entry_c_o (rom_entry)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      ms_q      <= '0;
      idx_q     <= '0;
      code_q    <= REST;
      dur_q     <= '0;
      half_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      note_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      dur_q     <= dur_d;
      half_q    <= half_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      note_en_q <= note_en_d;
    end
  end

  // Next-state, timing counters and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    idx_d     = idx_q;
    code_d    = code_q;
    dur_d     = dur_q;
    half_d    = half_q;
    ms_tick   = (pre_q == PRE_LAST);
    play_last = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        code_d  = rom_entry.code;
        dur_d   = rom_entry.dur_ms;
        half_d  = half_period_of(rom_entry.code);
        pre_d   = '0;
        ms_d    = '0;
        state_d = PLAY;
      end
      PLAY: begin
        if (ms_tick) begin
          pre_d = '0;
          if (ms_q == play_last) begin
            ms_d    = '0;
            state_d = GAP;
          end else begin
            ms_d = ms_q + DUR_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      GAP: begin
        if (ms_tick) begin
          pre_d = '0;
          if (ms_q == GAP_LAST) begin
            ms_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = LOAD;
            end
          end else begin
            ms_d = ms_q + DUR_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort takes effect from any active state.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      pre_d   = '0;
      ms_d    = '0;
    end

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    // Tone stays on through the final PLAY cycle and drops one cycle after leaving PLAY,
    // except on abort where it drops immediately.
    note_en_d = (state_q == PLAY) && (state_d != IDLE) && (code_q != REST);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign note_en     = note_en_q;
  assign half_period = half_q;
  assign note_idx    = idx_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a slow instance (MS_DIV=10) for exact timing, a fast instance
// (MS_DIV=1) for whole-song runs checked against a note scoreboard.
module tb_song_sequencer;

  localparam int F_MS  = 1;
  localparam int F_GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;

  logic        s_busy, s_done, s_note_en;
  logic [16:0] s_half;
  logic [4:0]  s_idx;
  logic        f_busy, f_done, f_note_en;
  logic [16:0] f_half;
  logic [4:0]  f_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int idx;
    int hp;
    int len;
  } exp_t;
  exp_t sb[$];

  int exp_hp [25] = '{127551, 127551, 113636, 127551, 95556, 101239,
                      127551, 127551, 113636, 127551, 85131, 95556,
                      127551, 127551, 63776, 75844, 95556, 101239, 113636,
                      71586, 71586, 75844, 95556, 85131, 95556};
  int exp_dur [25] = '{250, 250, 500, 500, 500, 1000,
                       250, 250, 500, 500, 500, 1000,
                       250, 250, 500, 500, 500, 500, 1000,
                       250, 250, 500, 500, 500, 1000};

  song_sequencer #(.MS_DIV(10), .GAP_MS(2), .SONG_LEN(25)) u_slow (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .busy(s_busy), .done(s_done), .note_en(s_note_en),
    .half_period(s_half), .note_idx(s_idx)
  );

  song_sequencer #(.MS_DIV(F_MS), .GAP_MS(F_GAP), .SONG_LEN(25)) u_fast (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .busy(f_busy), .done(f_done), .note_en(f_note_en),
    .half_period(f_half), .note_idx(f_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (3) step();
    total++;
    if ({s_busy, s_done, s_note_en, s_half, s_idx} !== 25'd0) begin
      bad++; $display("FAIL reset_slow got=%h want=0", {s_busy, s_done, s_note_en, s_half, s_idx});
    end
    total++;
    if ({f_busy, f_done, f_note_en, f_half, f_idx} !== 25'd0) begin
      bad++; $display("FAIL reset_fast got=%h want=0", {f_busy, f_done, f_note_en, f_half, f_idx});
    end
    rst = 1'b0;
    step();
  endtask

  // Exact cycle timing of the first note on the slow instance.
  task automatic test_latency();
    int s;
    start = 1'b1; s = cyc + 1;
    step(); start = 1'b0;           // cyc == s, LOAD
    step();                         // s+1, PLAY entered
    total++;
    if (s_note_en !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", s_note_en); end
    step();                         // s+2
    total++;
    if (s_note_en !== 1'b1) begin bad++; $display("FAIL lat_rise got=%b want=1", s_note_en); end
    total++;
    if (s_half !== 17'd127551 || s_idx !== 5'd0 || s_busy !== 1'b1) begin
      bad++; $display("FAIL lat_first half=%0d idx=%0d busy=%b want 127551/0/1", s_half, s_idx, s_busy);
    end
    while (cyc < s + 2501) step();
    total++;
    if (s_note_en !== 1'b1) begin bad++; $display("FAIL lat_last_on got=%b want=1", s_note_en); end
    step();
    total++;
    if (s_note_en !== 1'b0) begin bad++; $display("FAIL lat_fall got=%b want=0", s_note_en); end
    while (cyc < s + 2520) step();
    total++;
    if (s_idx !== 5'd0) begin bad++; $display("FAIL gap_idx got=%0d want=0", s_idx); end
    step();
    total++;
    if (s_idx !== 5'd1) begin bad++; $display("FAIL next_idx got=%0d want=1", s_idx); end
    step(); step();
    total++;
    if (s_note_en !== 1'b1 || s_half !== 17'd127551) begin
      bad++; $display("FAIL second_note en=%b half=%0d want 1/127551", s_note_en, s_half);
    end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (s_busy !== 1'b0 || s_note_en !== 1'b0) begin
      bad++; $display("FAIL lat_stop busy=%b en=%b want 0/0", s_busy, s_note_en);
    end
  endtask

  // Whole song on the fast instance; optionally pokes start during PLAY and GAP.
  task automatic test_full_run(input bit disturb);
    int s, exp_total, run, dones, done_at, notes;
    bit prev_en, finished;
    exp_t e;
    sb.delete();
    exp_total = 0;
    for (int i = 0; i < 25; i++) begin
      sb.push_back('{idx: i, hp: exp_hp[i], len: exp_dur[i] * F_MS});
      exp_total += 1 + exp_dur[i] * F_MS + F_GAP * F_MS;
    end
    e = '{idx: -1, hp: 0, len: 0};
    run = 0; dones = 0; done_at = -1; notes = 0; prev_en = 1'b0; finished = 1'b0;
    start = 1'b1; s = cyc + 1;
    step(); start = 1'b0;
    for (int k = 0; k < 20000 && !finished; k++) begin
      start = 1'b0;
      if (f_note_en && !prev_en) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_extra idx=%0d want no more notes", f_idx);
        end else begin
          e = sb.pop_front();
          if (f_idx !== 5'(e.idx) || f_half !== 17'(e.hp)) begin
            bad++; $display("FAIL note idx=%0d half=%0d want %0d/%0d", f_idx, f_half, e.idx, e.hp);
          end
        end
        run = 1;
        if (disturb && notes == 2) start = 1'b1;
        notes++;
      end else if (f_note_en) begin
        run++;
      end
      if (!f_note_en && prev_en) begin
        total++;
        if (run != e.len) begin bad++; $display("FAIL note_len idx=%0d got=%0d want=%0d", e.idx, run, e.len); end
        if (disturb && notes == 6) start = 1'b1;
      end
      if (f_done) begin dones++; done_at = cyc; end
      if (done_at >= 0 && cyc == done_at + 1) begin
        total++;
        if (f_busy !== 1'b0 || f_idx !== 5'd24) begin
          bad++; $display("FAIL after_done busy=%b idx=%0d want 0/24", f_busy, f_idx);
        end
        finished = 1'b1;
      end
      prev_en = f_note_en;
      step();
    end
    start = 1'b0;
    total++;
    if (!finished) begin bad++; $display("FAIL run_timeout got=unfinished want=done"); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL done_count got=%0d want=1", dones); end
    total++;
    if (done_at != s + exp_total) begin
      bad++; $display("FAIL done_time got=%0d want=%0d", done_at - s, exp_total);
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_left got=%0d want=0", sb.size()); end
  endtask

  // Abort during entry 3, then restart from entry 0.
  task automatic test_stop();
    int hi;
    bit found;
    found = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      if (f_note_en && f_idx == 5'd3) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin bad++; $display("FAIL stop_wait got=timeout want=idx3"); end
    repeat (5) step();
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (f_busy !== 1'b0 || f_note_en !== 1'b0 || f_done !== 1'b0 || f_half !== 17'd127551) begin
      bad++; $display("FAIL stop busy=%b en=%b done=%b half=%0d want 0/0/0/127551",
                      f_busy, f_note_en, f_done, f_half);
    end
    hi = 0;
    repeat (50) begin step(); if (f_done || f_busy || f_note_en) hi++; end
    total++;
    if (hi != 0) begin bad++; $display("FAIL stop_quiet got=%0d want=0", hi); end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    total++;
    if (f_note_en !== 1'b1 || f_idx !== 5'd0 || f_half !== 17'd127551) begin
      bad++; $display("FAIL restart en=%b idx=%0d half=%0d want 1/0/127551", f_note_en, f_idx, f_half);
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    total++;
    if (f_busy !== 1'b0 || s_busy !== 1'b0) begin
      bad++; $display("FAIL both_idle busy=%b/%b want 0/0", f_busy, s_busy);
    end
    step();
    total++;
    if (f_busy !== 1'b0) begin bad++; $display("FAIL both_idle2 got=%b want=0", f_busy); end
  endtask

  // Reset mid-note and during the gap after entry 10.
  task automatic test_reset_mid();
    bit found, prev_en;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    total++;
    if (f_note_en !== 1'b1) begin bad++; $display("FAIL pre_rst_en got=%b want=1", f_note_en); end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if (f_note_en !== 1'b0 || f_busy !== 1'b0) begin
      bad++; $display("FAIL rst_note en=%b busy=%b want 0/0", f_note_en, f_busy);
    end
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0; prev_en = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      if (f_idx == 5'd10 && prev_en && !f_note_en) found = 1'b1;
      else begin prev_en = f_note_en; step(); end
    end
    total++;
    if (!found) begin bad++; $display("FAIL gap10_wait got=timeout want=gap"); end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if ({f_busy, f_done, f_note_en, f_half, f_idx} !== 25'd0) begin
      bad++; $display("FAIL rst_gap got=%h want=0", {f_busy, f_done, f_note_en, f_half, f_idx});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_run(1'b0);
    test_full_run(1'b1);
    test_stop();
    test_start_stop_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
